// File: rtl/serial_cmp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmp_ctrl_pkg
// Purpose  : Shared definitions for the bit-serial comparator controller.
//            Holds the FSM state encoding used by serial_cmp_ctrl.
// Revision : 1.0  initial release
// ============================================================================
package serial_cmp_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : serial_cmp_ctrl_pkg
`default_nettype wire

// File: rtl/serial_cmp_ctrl_bit_eq_cell.sv
`default_nettype none
// ============================================================================
// Module   : bit_eq_cell
// Purpose  : Shared combinational 1-bit equality cell (XNOR).
// Ports    : x, y  - bits under comparison
//            e     - 1 when x == y
// Revision : 1.0  initial release
// ============================================================================
module bit_eq_cell (
    input  logic x,
    input  logic y,
    output logic e
);

    assign e = (x & y) | (~x & ~y);

endmodule : bit_eq_cell
`default_nettype wire

// File: rtl/serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmp_ctrl
// Purpose  : Bit-serial magnitude/equality comparator controller. Latches two
//            N-bit operands on start, walks them MSB-first through a single
//            1-bit equality cell and reports eq/gt/lt plus the number of bits
//            examined.
// Ports    : clk       - system clock, rising edge
//            rst       - synchronous reset, active-high
//            start     - request, accepted only while ready=1
//            a, b      - operands, sampled on the accepting edge
//            ready     - high in IDLE
//            busy      - high in SHIFT
//            done      - one-cycle pulse, results valid from this cycle
//            eq/gt/lt  - unsigned comparison result (exactly one set at done)
//            bit_count - bits examined by the last operation (1..N)
// Revision : 1.0  initial release
// ============================================================================
module serial_cmp_ctrl
    import serial_cmp_ctrl_pkg::*;
#(
    parameter int N          = 8,
    parameter int EARLY_EXIT = 1,
    parameter int CW         = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          eq,
    output logic          gt,
    output logic          lt,
    output logic [CW-1:0] bit_count
);

    localparam logic [CW-1:0] C_LAST_COUNT = CW'(N);
    localparam logic [CW-1:0] C_ONE        = CW'(1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_sra;
    logic [N-1:0]  r_srb;
    logic [CW-1:0] r_cnt;
    logic          r_mis;        // a mismatch has already been recorded
    logic          r_eq;
    logic          r_gt;
    logic          r_lt;
    logic [CW-1:0] r_bit_count;

    logic          w_e;
    logic [CW-1:0] w_cnt_next;
    logic          w_first_mis;
    logic          w_last;
    logic          w_finish;

    bit_eq_cell u_cell (
        .x (r_sra[N-1]),
        .y (r_srb[N-1]),
        .e (w_e)
    );

    assign w_cnt_next  = r_cnt + C_ONE;
    assign w_first_mis = ~w_e & ~r_mis;
    assign w_last      = (w_cnt_next == C_LAST_COUNT);
    // Without early exit the scan always runs to the last bit; gt/lt are
    // frozen by r_mis at the first mismatch.
    assign w_finish    = w_last | ((EARLY_EXIT != 0) & w_first_mis);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sra       <= '0;
            r_srb       <= '0;
            r_cnt       <= '0;
            r_mis       <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_bit_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sra       <= a;
                        r_srb       <= b;
                        r_cnt       <= '0;
                        r_mis       <= 1'b0;
                        r_eq        <= 1'b0;
                        r_gt        <= 1'b0;
                        r_lt        <= 1'b0;
                        r_bit_count <= '0;
                        r_state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_cnt <= w_cnt_next;
                    r_sra <= {r_sra[N-2:0], 1'b0};
                    r_srb <= {r_srb[N-2:0], 1'b0};
                    if (w_first_mis) begin
                        r_mis <= 1'b1;
                        r_gt  <= r_sra[N-1];
                        r_lt  <= ~r_sra[N-1];
                    end
                    if (w_finish) begin
                        r_state     <= ST_DONE;
                        r_bit_count <= w_cnt_next;
                        r_eq        <= ~r_mis & w_e;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_SHIFT);
    assign done      = (r_state == ST_DONE);
    assign eq        = r_eq;
    assign gt        = r_gt;
    assign lt        = r_lt;
    assign bit_count = r_bit_count;

endmodule : serial_cmp_ctrl
`default_nettype wire

// File: tb/tb_serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_cmp_ctrl
// Purpose  : Self-checking bench for serial_cmp_ctrl. Two instances are used,
//            index 0 with EARLY_EXIT=0 and index 1 with EARLY_EXIT=1.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_cmp_ctrl;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        start;
    logic [1:0][7:0]   a;
    logic [1:0][7:0]   b;

    logic ready0, busy0, done0, eq0, gt0, lt0;
    logic ready1, busy1, done1, eq1, gt1, lt1;
    logic [3:0] bc0, bc1;

    logic [1:0]      ready, busy, done, eq, gt, lt;
    logic [1:0][3:0] bc;
    assign ready = {ready1, ready0};
    assign busy  = {busy1, busy0};
    assign done  = {done1, done0};
    assign eq    = {eq1, eq0};
    assign gt    = {gt1, gt0};
    assign lt    = {lt1, lt0};
    assign bc    = {bc1, bc0};

    serial_cmp_ctrl #(.N(N), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]),
        .ready(ready0), .busy(busy0), .done(done0),
        .eq(eq0), .gt(gt0), .lt(lt0), .bit_count(bc0)
    );

    serial_cmp_ctrl #(.N(N), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]),
        .ready(ready1), .busy(busy1), .done(done1),
        .eq(eq1), .gt(gt1), .lt(lt1), .bit_count(bc1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Bits examined: all N unless early exit stops at the first differing
    // bit counted from the MSB.
    function automatic int ref_bits(input int ee, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] diff;
        diff = x ^ y;
        if (ee == 0 || diff == 8'h00) return N;
        for (int i = N - 1; i >= 0; i--)
            if (diff[i]) return N - i;
        return N;
    endfunction

    // Called at a negedge with ready[d]=1; returns at the negedge where done
    // is seen (lat = cycle index of that negedge, 0 if never seen).
    task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                          input bit noise, output int lat);
        start[d] = 1'b1;
        a[d] = av;
        b[d] = bv;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start[d] = 1'b0;
            if (done[d]) begin
                lat = k;
                break;
            end
            if (noise) begin
                a[d] = 8'($urandom);
                b[d] = 8'($urandom);
                if (k == 3 || k == 5) start[d] = 1'b1;
            end
        end
        if (lat == 0) chk($sformatf("timeout d=%0d", d), 0, 1);
    endtask

    task automatic check_res(input string tag, input int d, input int lat,
                             input int e_lat, input int e_eq, input int e_gt,
                             input int e_lt, input int e_bc);
        chk({tag, ".latency"}, lat, e_lat);
        chk({tag, ".eq"}, int'(eq[d]), e_eq);
        chk({tag, ".gt"}, int'(gt[d]), e_gt);
        chk({tag, ".lt"}, int'(lt[d]), e_lt);
        chk({tag, ".bit_count"}, int'(bc[d]), e_bc);
    endtask

    // Results must hold through IDLE with ready high and no further done.
    task automatic hold_check(input string tag, input int d, input int ncyc,
                              input int e_eq, input int e_gt, input int e_lt, input int e_bc);
        int act, exp;
        exp = (1 << 7) | (e_eq << 6) | (e_gt << 5) | (e_lt << 4) | e_bc;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            act = (int'(ready[d]) << 7) | (int'(done[d]) << 8) | (int'(eq[d]) << 6)
                | (int'(gt[d]) << 5) | (int'(lt[d]) << 4) | int'(bc[d]);
            chk({tag, ".hold"}, act, exp);
        end
    endtask

    typedef struct {
        int         d;
        logic [7:0] a;
        logic [7:0] b;
        int         eq;
        int         gt;
        int         lt;
        int         bc;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, dm, rm, nd, d, mode, eb;
        logic [7:0] ra, rb;

        vecs[0] = '{1, 8'hA5, 8'hA5, 1, 0, 0, 8, 9};
        vecs[1] = '{1, 8'h80, 8'h7F, 0, 1, 0, 1, 2};
        vecs[2] = '{1, 8'h3C, 8'h3D, 0, 0, 1, 8, 9};
        vecs[3] = '{0, 8'h40, 8'h3F, 0, 1, 0, 8, 9};
        vecs[4] = '{0, 8'h3C, 8'h3D, 0, 0, 1, 8, 9};
        vecs[5] = '{1, 8'h00, 8'hFF, 0, 0, 1, 1, 2};
        vecs[6] = '{1, 8'h12, 8'h16, 0, 0, 1, 6, 7};
        vecs[7] = '{0, 8'h80, 8'h7F, 0, 1, 0, 8, 9};

        rst = 1'b1;
        start = '0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset.ready d=%0d", i), int'(ready[i]), 1);
            chk($sformatf("reset.busy d=%0d", i), int'(busy[i]), 0);
            chk($sformatf("reset.outs d=%0d", i),
                int'({done[i], eq[i], gt[i], lt[i], bc[i]}), 0);
        end

        // Directed vectors.
        foreach (vecs[i]) begin
            run_op(vecs[i].d, vecs[i].a, vecs[i].b, 1'b0, lat);
            check_res($sformatf("vec%0d", i), vecs[i].d, lat, vecs[i].lat,
                      vecs[i].eq, vecs[i].gt, vecs[i].lt, vecs[i].bc);
            hold_check($sformatf("vec%0d", i), vecs[i].d, 2,
                       vecs[i].eq, vecs[i].gt, vecs[i].lt, vecs[i].bc);
        end

        // start pulses and operand changes while busy are ignored.
        run_op(1, 8'hA5, 8'hA5, 1'b1, lat);
        check_res("ignore", 1, lat, 9, 1, 0, 0, 8);
        hold_check("ignore", 1, 3, 1, 0, 0, 8);

        // start held high: back-to-back operations with one ready cycle.
        start[1] = 1'b1;
        a[1] = 8'h80;
        b[1] = 8'h7F;
        dm = 0;
        rm = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (done[1]) dm |= (1 << k);
            if (ready[1]) rm |= (1 << k);
            if (k == 5) begin
                chk("b2b.gt", int'(gt[1]), 1);
                chk("b2b.bit_count", int'(bc[1]), 1);
                start[1] = 1'b0;
            end
        end
        chk("b2b.done_cycles", dm, (1 << 2) | (1 << 5));
        chk("b2b.ready_cycles", rm, (1 << 3) | (1 << 6));

        // rst in the middle of SHIFT, together with start: rst wins.
        start[1] = 1'b1;
        a[1] = 8'hFF;
        b[1] = 8'hFF;
        nd = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start[1] = 1'b0;
            if (done[1]) nd++;
            if (k == 4) begin
                rst = 1'b1;
                start[1] = 1'b1;
            end
            if (k == 5) begin
                chk("rst.ready", int'(ready[1]), 1);
                chk("rst.busy", int'(busy[1]), 0);
                chk("rst.outs1", int'({eq[1], gt[1], lt[1], bc[1]}), 0);
                chk("rst.outs0", int'({eq[0], gt[0], lt[0], bc[0]}), 0);
                rst = 1'b0;
                start[1] = 1'b0;
            end
        end
        chk("rst.no_done", nd, 0);

        // Randomized operations against the reference compare.
        for (int n = 0; n < 1000; n++) begin
            d = n % 2;
            ra = 8'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0) rb = ra;
            else if (mode == 1) rb = ra ^ (8'h01 << $urandom_range(0, 7));
            else rb = 8'($urandom);
            eb = ref_bits(d, ra, rb);
            run_op(d, ra, rb, 1'b0, lat);
            check_res($sformatf("rnd%0d d=%0d a=%02h b=%02h", n, d, ra, rb), d, lat, eb + 1,
                      int'(ra == rb), int'(ra > rb), int'(ra < rb), eb);
            hold_check($sformatf("rnd%0d", n), d, 1,
                       int'(ra == rb), int'(ra > rb), int'(ra < rb), eb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_cmp_ctrl
`default_nettype wire

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
Bit-serial magnitude/equality comparator controller for two N-bit words.
- Latches both operands on a start handshake.
- Walks the words MSB-first, one bit per clock, through a single 1-bit equality cell.
- Stops at the first mismatching bit, or after all N bits, and reports eq/gt/lt plus the number of bits examined.
- Used where area matters more than latency; it sits between a requester FSM and the shared combinational 1-bit cell.

Parameters:
N, 8, operand width in bits (N >= 2)
EARLY_EXIT, 1, 1 = terminate at first mismatch; 0 = always scan all N bits, result taken from first mismatch
CW, $clog2(N+1), width of bit_count (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; accepted only when ready=1
a  in  N  operand A, sampled on the accepting edge
b  in  N  operand B, sampled on the accepting edge
ready  out  1  high in IDLE only
busy  out  1  high in SHIFT only
done  out  1  single-cycle pulse, results valid from this cycle
eq  out  1  A == B
gt  out  1  A > B (unsigned)
lt  out  1  A < B (unsigned)
bit_count  out  CW  bits examined in the last operation (1..N)

Behaviour:
- Interface: one clock clk. Reset rst is synchronous and active-high.
- States: IDLE, SHIFT, DONE.
- Reset values:
  - state=IDLE, shift registers=0, bit counter=0, first-mismatch flag=0.
  - ready=1; busy=0, done=0, eq=0, gt=0, lt=0, bit_count=0.
- IDLE:
  - ready=1.
  - start=1 at an edge: sra<=a, srb<=b, counter<=0, eq/gt/lt<=0, mismatch flag<=0, go SHIFT.
- SHIFT (busy=1, ready=0):
  - The cell compares sra[N-1] with srb[N-1] combinationally.
  - Each edge: counter++ and sra/srb shift left by 1, zero fill.
  - Bit equal and counter reaches N: go DONE with eq=1.
  - Bit differs, no earlier mismatch recorded:
    - record gt=sra[N-1] and lt=~sra[N-1];
    - EARLY_EXIT=1: go DONE immediately;
    - EARLY_EXIT=0: continue to N bits; later mismatches do not alter gt/lt.
  - Exactly one of eq/gt/lt is 1 when done pulses.
- DONE:
  - done=1 for exactly one cycle.
  - bit_count=counter (registered).
  - Next state is IDLE unconditionally.
- Latency, counting cycle 0 as the accepting edge and cycle 1 as the first SHIFT cycle:
  - done is high in cycle j+1, where j = bits examined.
  - Equal operands: done in cycle N+1.
  - EARLY_EXIT=1, mismatch at bit index i (MSB=N-1): j = N-i.
  - EARLY_EXIT=0: always j=N.
- Result hold: eq/gt/lt/bit_count hold after DONE through IDLE until the next accepting edge, then clear.
- Boundary conditions:
  - start while busy or in DONE: ignored, not queued.
  - start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
  - a/b changing during SHIFT: no effect.
  - rst mid-SHIFT or in DONE: IDLE next cycle, no done pulse, outputs return to reset values.
  - rst and start in the same cycle: rst wins.
  - Counter never exceeds N; no wrap.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
- Sub-module: bit_eq_cell, combinational XNOR, (x, y) -> e = x&y | ~x&~y.
  - One instance inside serial_cmp_ctrl.
  - The controller derives gt/lt from sra[N-1] when e=0.
- Everything else (shift registers, counter, FSM) stays in this module.

Test Plan:
- N=8, EARLY_EXIT=1, a=8'hA5, b=8'hA5 -> done in cycle 9, eq=1, gt=0, lt=0, bit_count=8; results held in following IDLE cycles.
- a=8'h80, b=8'h7F -> done in cycle 2, gt=1, lt=0, eq=0, bit_count=1.
- a=8'h3C, b=8'h3D -> done in cycle 9, lt=1, bit_count=8; with EARLY_EXIT=0 and a=8'h40, b=8'h3F -> done in cycle 9, gt=1, bit_count=8.
- start pulsed in cycles 3 and 5 of a running operation -> ignored, single done; start held high continuously -> back-to-back operations with one ready cycle between DONE and the next accept.
- rst asserted in cycle 4 of an a=8'hFF, b=8'hFF operation -> ready=1 in cycle 5, no done pulse, eq/gt/lt/bit_count=0.
- Random a, b over 1000 operations, both EARLY_EXIT values -> eq/gt/lt match unsigned reference compare, bit_count matches the MSB-first first-mismatch index rule.
